// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial sequence generator.
// State encoding, default sizing and the reference detector pattern.
package seq_gen_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_REP_W   = 4;
  localparam int DEF_GAP_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3
  } state_t;

  localparam logic [5:0] PAT_101010     = 6'b101010;
  localparam int         PAT_101010_LEN = 6;

endpackage

// File: rtl/pattern_shifter.sv
// MSB-first pattern shifter with parallel load, reload and last-bit flag.
// The bit currently on the line lives in the parent; rest holds what follows.
module pattern_shifter #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               load_bit,
  output logic               first_bit,
  output logic               next_bit,
  output logic               last
);

  localparam logic [LEN_W:0] ML = (LEN_W+1)'(MAX_LEN);

  logic [LEN_W:0]     shamt;
  logic [MAX_LEN-1:0] aligned;
  logic [MAX_LEN-1:0] al_q;
  logic [MAX_LEN-2:0] rest;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;

  // left-justify so pattern[len-1] lands on the MSB
  assign shamt   = ML - {1'b0, len};
  assign aligned = pattern << shamt;

  assign load_bit  = aligned[MAX_LEN-1];
  assign first_bit = al_q[MAX_LEN-1];
  assign next_bit  = rest[MAX_LEN-2];
  assign last      = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_q  <= '0;
      rest  <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      al_q  <= aligned;
      rest  <= aligned[MAX_LEN-2:0];
      len_q <= len;
      cnt   <= len - 1'b1;
    end else if (reload) begin
      rest <= al_q[MAX_LEN-2:0];
      cnt  <= len_q - 1'b1;
    end else if (shift) begin
      rest <= {rest[MAX_LEN-3:0], 1'b0};
      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: repeats a captured pattern with optional gaps.
// Feeds the single-bit input of the sequence detector.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int REP_W   = DEF_REP_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  localparam logic [LEN_W-1:0] ML = LEN_W'(MAX_LEN);

  state_t           st;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  logic len_ok;
  logic load;
  logic reload;
  logic shift;
  logic more;
  logic load_bit;
  logic first_bit;
  logic next_bit;
  logic last;

  assign state  = st;
  assign len_ok = (len != '0) && (len <= ML);
  assign load   = (st == ST_IDLE) && start && len_ok;
  assign shift  = (st == ST_SEND) && !last;
  assign more   = (rep_cnt != REP_W'(1));
  assign reload = ((st == ST_SEND) && last && more && (gap_q == '0))
               || ((st == ST_GAP) && (gap_cnt == GAP_W'(1)));

  pattern_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load),
    .reload    (reload),
    .shift     (shift),
    .pattern   (pattern),
    .len       (len),
    .load_bit  (load_bit),
    .first_bit (first_bit),
    .next_bit  (next_bit),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_IDLE;
      rep_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          done <= 1'b0;
          if (load) begin
            rep_cnt <= (reps == '0) ? REP_W'(1) : reps;
            gap_q   <= gap;
            out     <= load_bit;
            valid   <= 1'b1;
            busy    <= 1'b1;
            st      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!last) begin
            out <= next_bit;
          end else if (more) begin
            rep_cnt <= rep_cnt - 1'b1;
            if (gap_q != '0) begin
              gap_cnt <= gap_q;
              out     <= 1'b0;
              valid   <= 1'b0;
              st      <= ST_GAP;
            end else begin
              out <= first_bit;
            end
          end else begin
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            st    <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            out   <= first_bit;
            valid <= 1'b1;
            st    <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          st    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator.
// Expected streams are hand-computed constants per scenario.
module tb_sequence_generator;
  import seq_gen_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  reps;
  logic [3:0]  gap;
  logic        out;
  logic        valid;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  sequence_generator dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .gap     (gap),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kick(input logic [15:0] p, input logic [4:0] l,
                      input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    pattern = p;
    len     = l;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    pattern = '0;
    len = '0;
    reps = '0;
    gap = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset: out=%b valid=%b busy=%b done=%b state=%0d want all 0",
               out, valid, busy, done, state);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d busy=%b want 0 0", state, busy);
    end
  endtask

  task automatic test_basic;
    logic [5:0] eo;
    eo = 6'b101010;
    kick(16'h002A, 5'd6, 4'd1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out !== eo[5-i] || valid !== 1'b1 || busy !== 1'b1 || state !== 3'd1) begin
        errors++;
        $display("FAIL basic_bit%0d: out=%b valid=%b busy=%b state=%0d want %b 1 1 1",
                 i, out, valid, busy, state, eo[5-i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b state=%0d want 1 0 0 3",
               done, busy, valid, state);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL basic_idle: done=%b state=%0d want 0 0", done, state);
    end
  endtask

  task automatic test_gap;
    logic [7:0] eo;
    logic [7:0] ev;
    logic [2:0] es;
    eo = 8'b10100101;
    ev = 8'b11100111;
    kick(16'h0005, 5'd3, 4'd2, 4'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      es = ev[7-i] ? 3'd1 : 3'd2;
      checks++;
      if (out !== eo[7-i] || valid !== ev[7-i] || busy !== 1'b1 || state !== es) begin
        errors++;
        $display("FAIL gap_cyc%0d: out=%b valid=%b busy=%b state=%0d want %b %b 1 %0d",
                 i + 1, out, valid, busy, state, eo[7-i], ev[7-i], es);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL gap_done: done=%b state=%0d want 1 3", done, state);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] eo;
    logic [7:0] ed;
    logic [5:0] hist;
    logic       det;
    eo = 8'b10101010;
    ed = 8'b00000101;
    hist = '0;
    kick(16'h0002, 5'd2, 4'd4, 4'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hist = {hist[4:0], out};
      det = (i >= 5) && (hist == PAT_101010);
      checks++;
      if (out !== eo[7-i] || valid !== 1'b1 || det !== ed[7-i]) begin
        errors++;
        $display("FAIL b2b_bit%0d: out=%b valid=%b det=%b want %b 1 %b",
                 i + 1, out, valid, det, eo[7-i], ed[7-i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL b2b_done: done=%b state=%0d want 1 3", done, state);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    kick(16'h002A, 5'd0, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL len0_cyc%0d: state=%0d busy=%b done=%b valid=%b want 0 0 0 0",
                 i + 1, state, busy, done, valid);
      end
    end
    kick(16'hFFFF, 5'd17, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL len17_cyc%0d: state=%0d busy=%b done=%b valid=%b want 0 0 0 0",
                 i + 1, state, busy, done, valid);
      end
    end
  endtask

  task automatic test_restart;
    logic [5:0] eo;
    eo = 6'b101010;
    kick(16'h002A, 5'd6, 4'd1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out !== eo[5-i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL restart_bit%0d: out=%b valid=%b want %b 1",
                 i, out, valid, eo[5-i]);
      end
      if (i == 1) begin
        start = 1'b1;
        pattern = 16'h0015;
        len = 5'd3;
        reps = 4'd3;
      end
      if (i == 2) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL restart_done: done=%b state=%0d want 1 3", done, state);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state !== 3'd0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: state=%0d valid=%b busy=%b want 0 0 0",
               state, valid, busy);
    end
  endtask

  task automatic test_reps0;
    kick(16'h0003, 5'd2, 4'd0, 4'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 1'b1 || valid !== 1'b1 || state !== 3'd1) begin
        errors++;
        $display("FAIL reps0_bit%0d: out=%b valid=%b state=%0d want 1 1 1",
                 i, out, valid, state);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL reps0_done: done=%b state=%0d want 1 3", done, state);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reps0_idle: state=%0d done=%b want 0 0", state, done);
    end
  endtask

  task automatic test_async_reset;
    kick(16'h002A, 5'd6, 4'd1, 4'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: out=%b valid=%b want 1 1", out, valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL areset_now: out=%b valid=%b busy=%b state=%0d want 0 0 0 0",
               out, valid, busy, state);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || state !== 3'd0) begin
        errors++;
        $display("FAIL areset_hold%0d: done=%b state=%0d want 0 0", i, done, state);
      end
    end
    reset = 1'b1;
    test_basic();
  endtask

  task automatic test_boundary;
    int vcnt;
    int donecyc;
    int p;
    logic eb;
    vcnt = 0;
    donecyc = 0;
    kick(16'h8001, 5'd16, 4'd15, 4'd15);
    for (int cyc = 1; cyc <= 470; cyc++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        p = vcnt % 16;
        eb = (p == 0) || (p == 15);
        checks++;
        if (out !== eb) begin
          errors++;
          $display("FAIL bound_bit%0d: out=%b want %b", vcnt, out, eb);
        end
        vcnt++;
      end
      if (done === 1'b1) begin
        donecyc = cyc;
        break;
      end
    end
    checks++;
    if (donecyc != 451) begin
      errors++;
      $display("FAIL bound_done_cycle: got %0d want 451 (0 = timeout)", donecyc);
    end
    checks++;
    if (vcnt != 240) begin
      errors++;
      $display("FAIL bound_valid_count: got %0d want 240", vcnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_illegal();
    test_restart();
    test_reps0();
    test_async_reset();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial bit-stream transmitter that drives the input of the Mealy sequence detector. It loads a programmable pattern of up to MAX_LEN bits and shifts it out MSB-first, one bit per clock. The pattern can be repeated a programmed number of times, with optional idle gap cycles between repetitions. The block is the source end of the single-bit serial interface consumed by detect_sequence, and it serves both as on-chip stimulus and as a loop-back partner.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits.
- LEN_W, 5, width of the len input; must satisfy 2^LEN_W > MAX_LEN.
- REP_W, 4, width of the repeat-count input.
- GAP_W, 4, width of the inter-repetition gap input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 asserts; deassertion is synchronous to clk).
- start  input  1  request to begin transmission; sampled only in IDLE.
- pattern  input  MAX_LEN  pattern bits; bit len-1 is sent first, bit 0 last.
- len  input  LEN_W  number of pattern bits to send (1..MAX_LEN).
- reps  input  REP_W  repetition count; 0 is treated as 1.
- gap  input  GAP_W  idle cycles between repetitions (0 = back-to-back).
- out  output  1  serial data bit, registered.
- valid  output  1  high while out carries a pattern bit.
- busy  output  1  high from the start edge until the cycle before done.
- done  output  1  one-cycle pulse after the last bit of the last repetition.
- state  output  3  current FSM state encoding, exposed for debug and benches.

Behaviour:
- Reset (reset=0, asynchronous): out=0, valid=0, busy=0, done=0, state=IDLE, all internal counters cleared. Asserting reset mid-transmission aborts immediately with no done pulse.
- State encoding: IDLE=0, SEND=1, GAP=2, DONE=3. Encodings 4..7 are illegal and recover to IDLE on the next edge.
- IDLE: out=0, valid=0, busy=0.
  - On an edge with start=1 and 1<=len<=MAX_LEN, capture pattern, len, max(reps,1) and gap into internal registers.
  - At that same edge: out=pattern[len-1], valid=1, busy=1, state→SEND.
  - The first bit is therefore valid in the cycle immediately after the start edge.
- start with len=0 or len>MAX_LEN is ignored: stay in IDLE, no done pulse.
- SEND: each edge advances the bit index by one, sending the next lower bit.
  - After bit 0 of the current repetition, with repetitions remaining:
    - gap>0: state→GAP, out=0, valid=0.
    - gap=0: reload and drive pattern[len-1] on the next cycle, so repetitions are contiguous.
  - After bit 0 of the last repetition: state→DONE, out=0, valid=0.
- GAP: out=0, valid=0, busy=1 for exactly gap cycles, then state→SEND with out=pattern[len-1].
- DONE: done=1 and busy=0 for one cycle, then state→IDLE unconditionally.
  - start asserted during DONE is ignored. It is accepted only from IDLE, so the minimum spacing between transmissions is one IDLE cycle.
- start, and changes to pattern, len, reps or gap while busy=1 or in DONE, have no effect; the captured copies are used.
- Total valid cycles = reps*len. Start edge to done-high cycle = reps*len + (reps-1)*gap + 1 cycles.
- Counters: bit counter LEN_W bits, repetition counter REP_W bits, gap counter GAP_W bits; none may wrap. reps=2^REP_W-1 and gap=2^GAP_W-1 must work exactly.

Decomposition:
- Package seq_gen_pkg holds:
  - state encoding constants: ST_IDLE, ST_SEND, ST_GAP, ST_DONE;
  - default MAX_LEN, LEN_W, REP_W and GAP_W values;
  - the 101010 detector pattern constant, PAT_101010 = 6'b101010, with length 6.
- One sub-module: pattern_shifter. It performs a parallel load of pattern/len, shifts MSB-first on an enable, and flags the last bit. The FSM and the repetition and gap counters stay in sequence_generator.

Test Plan:
- Basic send: pattern=6'b101010, len=6, reps=1, gap=0, one-cycle start → out=1,0,1,0,1,0 on the 6 cycles after start, valid=1 for those 6 cycles; done=1 in cycle 7; busy=0 from cycle 7; state sequence 0→1(×6)→3→0.
- Repeat with gap: pattern=3'b101, len=3, reps=2, gap=2 → out=1,0,1,0,0,1,0,1, valid=1,1,1,0,0,1,1,1; done in cycle 9.
- Back-to-back plus loop-back: pattern=2'b10, len=2, reps=4, gap=0, out wired to detect_sequence.in → stream 10101010; detector out is high on the 6th and 8th bits (overlapping matches); done in cycle 9.
- Illegal and ignored requests:
  - len=0 with start → state stays 0, busy=0, no done.
  - start re-pulsed mid-SEND with a new pattern → original stream unchanged.
  - reps=0 → exactly one repetition.
- Asynchronous reset mid-stream: reset=0 between edges during the 3rd bit of a len=6 send → out, valid and busy drop to 0 immediately with state=0; no done. After release, a fresh start sends the full pattern.
- Boundary: len=MAX_LEN=16, pattern=16'h8001, reps=15, gap=15 → each repetition is 1, fourteen 0s, 1; 240 valid cycles; done in cycle 240+14*15+1=451.
